// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC operand sequencer.
//   mac_seq_state_t : sequencer FSM states
//   MAC_ACC_MULT    : accumulator width as a multiple of the operand width
//   STALL_CNT_WIDTH : width of the optional stall counter
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    SETTLE = 3'd4,
    RESULT = 3'd5
  } mac_seq_state_t;

  localparam int MAC_ACC_MULT    = 3;
  localparam int STALL_CNT_WIDTH = 16;

endpackage

// File: rtl/mac_seq.sv
// mac_seq: operand sequencer for an external multiply-accumulate unit.
// A start command latches a pair count, clears the MAC, pulls operand pairs
// from two ready/valid streams (one MAC enable per pair) and returns the
// final accumulator on a ready/valid result port.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   start, len            command (accepted only when idle), pair count
//   busy                  high whenever not idle
//   a_valid/a_data/a_ready  operand A stream
//   b_valid/b_data/b_ready  operand B stream
//   mac_en, mac_clr, mac_a, mac_b   drive the MAC En/Clr/Ain/Bin
//   mac_c                 MAC Cout
//   res_valid/res_data/res_ready    result stream
//   stall_cnt             RUN cycles without a fire (only with MAC_SEQ_STALL_CNT_EN)
//
// Build option: define MAC_SEQ_STALL_CNT_EN to add the stall counter.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one-cycle MAC clear
// RUN    | firing operand pairs until the count reaches zero
// DRAIN  | last mac_en is on the bus
// SETTLE | mac_c is final, captured into res_data
// RESULT | res_valid held until res_ready
module mac_seq
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [LEN_WIDTH-1:0]               len,
  output logic                               busy,
  input  logic                               a_valid,
  input  logic [DATA_WIDTH-1:0]              a_data,
  output logic                               a_ready,
  input  logic                               b_valid,
  input  logic [DATA_WIDTH-1:0]              b_data,
  output logic                               b_ready,
  output logic                               mac_en,
  output logic                               mac_clr,
  output logic [DATA_WIDTH-1:0]              mac_a,
  output logic [DATA_WIDTH-1:0]              mac_b,
  input  logic [MAC_ACC_MULT*DATA_WIDTH-1:0] mac_c,
  output logic                               res_valid,
  output logic [MAC_ACC_MULT*DATA_WIDTH-1:0] res_data,
  input  logic                               res_ready
`ifdef MAC_SEQ_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0]         stall_cnt
`endif
);

  mac_seq_state_t       state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q;
  logic                 fire;
  logic                 accept;

  assign accept = (state_q == IDLE) && start;
  // Both streams are consumed together so a pair is never split.
  assign fire   = (state_q == RUN) && a_valid && b_valid;

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    a_ready   = fire;
    b_ready   = fire;
    mac_clr   = (state_q == CLEAR);
    res_valid = (state_q == RESULT);
    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = (rem_q == '0) ? SETTLE : RUN;
      RUN:     if (fire && (rem_q == LEN_WIDTH'(1))) state_d = DRAIN;
      DRAIN:   state_d = SETTLE;
      SETTLE:  state_d = RESULT;
      RESULT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      mac_en   <= 1'b0;
      mac_a    <= '0;
      mac_b    <= '0;
      res_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) rem_q <= len;
      else if (fire) rem_q <= rem_q - LEN_WIDTH'(1);
      // Operands go to the MAC one cycle after the handshake; data holds otherwise.
      mac_en <= fire;
      if (fire) begin
        mac_a <= a_data;
        mac_b <= b_data;
      end
      if (state_q == SETTLE) res_data <= mac_c;
    end
  end

`ifdef MAC_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if ((state_q == RUN) && !fire && (stall_cnt != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: self-checking bench for mac_seq with a behavioural MAC beside it.
// Directed vectors from a table, a mid-run reset sequence, then random commands
// whose expected result and timing come from a sum-of-products model.
module tb_mac_seq;

  logic        clk = 1'b0;
  logic        rst, start, busy;
  logic [7:0]  len;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [7:0]  a_data, b_data;
  logic        mac_en, mac_clr;
  logic [7:0]  mac_a, mac_b;
  logic [23:0] mac_c;
  logic        res_valid, res_ready;
  logic [23:0] res_data;
`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  mac_seq #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_c(mac_c), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready)
`ifdef MAC_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Behavioural MAC in the parent: not affected by rst.
  logic [23:0] acc = '0;
  assign mac_c = acc;
  always @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= acc + 24'(mac_a) * 24'(mac_b);
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] va[8];
  logic [7:0] vb[8];
  int         vg[8];
  logic [7:0] exp_a = '0;
  logic [7:0] exp_b = '0;

  typedef struct {
    int          n;
    logic [7:0]  a[4];
    logic [7:0]  b[4];
    int          g[4];
    int          hold;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command using va/vb/vg and check every cycle up to the result
  // handshake. Timing: CLEAR at cycle 1, first possible fire at cycle 2,
  // result at N+4+stalls (3 for N=0).
  task automatic run_cmd(input int n, input int hold, input logic [23:0] expv, input string tag);
    int   idx, gap_left, gsum, lat;
    logic fire_prev, fire_now;
    gsum = 0;
    for (int i = 0; i < n; i++) gsum += vg[i];
    lat       = (n == 0) ? 3 : n + 4 + gsum;
    idx       = 0;
    gap_left  = (n > 0) ? vg[0] : 0;
    fire_prev = 1'b0;
    chk({tag, " idle"}, busy, 0);
    start = 1'b1; len = 8'(n); res_ready = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      chk({tag, " mac_clr"}, mac_clr, (cyc == 1));
      chk({tag, " mac_en"}, mac_en, fire_prev);
      chk({tag, " mac_a"}, mac_a, exp_a);
      chk({tag, " mac_b"}, mac_b, exp_b);
      chk({tag, " busy"}, busy, 1);
      chk({tag, " res_valid"}, res_valid, (cyc == lat));
      if (cyc == lat) begin
        chk({tag, " res_data"}, res_data, expv);
`ifdef MAC_SEQ_STALL_CNT_EN
        chk({tag, " stall_cnt"}, stall_cnt, gsum);
`endif
      end
      a_valid = 1'b0; b_valid = 1'b0;
      if (idx < n) begin
        a_data = va[idx]; b_data = vb[idx];
        a_valid = 1'b1; b_valid = 1'b1;
        if (cyc >= 2 && gap_left > 0) begin
          b_valid = 1'b0;
          b_data  = 8'($urandom);
          gap_left--;
        end
      end
      fire_now = (cyc >= 2) && (idx < n) && a_valid && b_valid;
      #1;
      chk({tag, " a_ready"}, a_ready, fire_now);
      chk({tag, " b_ready"}, b_ready, fire_now);
      if (fire_now) begin
        exp_a = va[idx]; exp_b = vb[idx];
        idx++;
        if (idx < n) gap_left = vg[idx];
      end
      fire_prev = fire_now;
      if (cyc < lat) step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; len = 8'd5;
      step();
      chk({tag, " hold valid"}, res_valid, 1);
      chk({tag, " hold data"}, res_data, expv);
      chk({tag, " hold mac_clr"}, mac_clr, 0);
    end
    res_ready = 1'b1; start = 1'b1; len = 8'd5;
    step();
    chk({tag, " busy after hs"}, busy, 0);
    chk({tag, " valid after hs"}, res_valid, 0);
    res_ready = 1'b0; start = 1'b0;
    step();
    chk({tag, " start ignored"}, busy, 0);
`ifdef MAC_SEQ_STALL_CNT_EN
    chk({tag, " stall held"}, stall_cnt, gsum);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] sum;
    int          n;
    tbl[0] = '{n: 1, a: '{2, 0, 0, 0},   b: '{2, 0, 0, 0},   g: '{0, 0, 0, 0}, hold: 0, exp: 24'd4};
    tbl[1] = '{n: 3, a: '{2, 3, 1, 0},   b: '{2, 4, 5, 0},   g: '{0, 2, 0, 0}, hold: 1, exp: 24'd21};
    tbl[2] = '{n: 0, a: '{0, 0, 0, 0},   b: '{0, 0, 0, 0},   g: '{0, 0, 0, 0}, hold: 0, exp: 24'd0};
    tbl[3] = '{n: 2, a: '{255, 255, 0, 0}, b: '{255, 255, 0, 0}, g: '{0, 0, 0, 0}, hold: 0, exp: 24'd130050};
    tbl[4] = '{n: 1, a: '{1, 0, 0, 0},   b: '{1, 0, 0, 0},   g: '{0, 0, 0, 0}, hold: 5, exp: 24'd1};

    rst = 1'b1; start = 1'b0; len = '0; res_ready = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    step(); step();
    chk("rst busy", busy, 0);
    chk("rst a_ready", a_ready, 0);
    chk("rst b_ready", b_ready, 0);
    chk("rst mac_en", mac_en, 0);
    chk("rst mac_clr", mac_clr, 0);
    chk("rst mac_a", mac_a, 0);
    chk("rst mac_b", mac_b, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst res_data", res_data, 0);
`ifdef MAC_SEQ_STALL_CNT_EN
    chk("rst stall_cnt", stall_cnt, 0);
`endif
    rst = 1'b0;
    step();

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 8; i++) begin
        va[i] = (i < 4) ? tbl[t].a[i] : 8'd0;
        vb[i] = (i < 4) ? tbl[t].b[i] : 8'd0;
        vg[i] = (i < 4) ? tbl[t].g[i] : 0;
      end
      run_cmd(tbl[t].n, tbl[t].hold, tbl[t].exp, $sformatf("vec%0d", t));
    end

    // Reset in RUN after the first of four pairs.
    start = 1'b1; len = 8'd4;
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'd7; b_data = 8'd9;
    step();
    start = 1'b0;
    step();
    chk("mid a_ready", a_ready, 1);
    step();
    chk("mid mac_en", mac_en, 1);
    chk("mid mac_a", mac_a, 7);
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
    step();
    chk("mid rst busy", busy, 0);
    chk("mid rst mac_en", mac_en, 0);
    chk("mid rst mac_clr", mac_clr, 0);
    chk("mid rst mac_a", mac_a, 0);
    chk("mid rst mac_b", mac_b, 0);
    chk("mid rst res_valid", res_valid, 0);
    chk("mid rst res_data", res_data, 0);
    chk("mid rst a_ready", a_ready, 0);
    rst = 1'b0; exp_a = '0; exp_b = '0;
    step();
    va[0] = 8'd2; vb[0] = 8'd2; vg[0] = 0;
    run_cmd(1, 0, 24'd4, "after rst");

    // Random commands against the sum-of-products model.
    for (int r = 0; r < 25; r++) begin
      n   = $urandom_range(0, 6);
      sum = '0;
      for (int i = 0; i < 8; i++) begin
        va[i] = 8'($urandom);
        vb[i] = 8'($urandom);
        vg[i] = $urandom_range(0, 2);
        if (i < n) sum = sum + 24'(va[i]) * 24'(vb[i]);
      end
      run_cmd(n, $urandom_range(0, 2), sum, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
# mac_seq

Operand sequencer that drives the `MAC` multiply-accumulate unit. It accepts a start command carrying a vector length and clears the accumulator. It then pulls paired operands from two ready/valid streams, issues one MAC enable per pair, and returns the final accumulated value on a ready/valid result port. It sits in the parent level beside the `MAC` instance, between the operand sources (FIFOs or memory readers) and the result consumer.

## Interface
- `DATA_WIDTH`, 8, operand width; accumulator/result width is 3*`DATA_WIDTH`
- `LEN_WIDTH`, 8, width of the vector-length field; must be ≤ `DATA_WIDTH`
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse/level; accepted only in IDLE
- `len`  in  LEN_WIDTH  number of operand pairs; sampled with `start`; 0 legal
- `busy`  out  1  high in every state except IDLE
- `a_valid` / `a_data`  in  1 / DATA_WIDTH  operand A stream
- `a_ready`  out  1  operand A consumed
- `b_valid` / `b_data`  in  1 / DATA_WIDTH  operand B stream
- `b_ready`  out  1  operand B consumed
- `mac_en`  out  1  to `MAC` `En`
- `mac_clr`  out  1  to `MAC` `Clr`
- `mac_a` / `mac_b`  out  DATA_WIDTH  to `MAC` `Ain` / `Bin`
- `mac_c`  in  3*DATA_WIDTH  from `MAC` `Cout`
- `res_valid` / `res_data`  out  1 / 3*DATA_WIDTH  result
- `res_ready`  in  1  result consumed
- `stall_cnt`  out  16  only with `MAC_SEQ_STALL_CNT_EN`

## Operation
- States:
  - IDLE: on `start`, latch `len` into the remaining counter and go to CLEAR.
  - CLEAR: `mac_clr`=1 for one cycle. If the latched length is 0, go to SETTLE; otherwise go to RUN.
  - RUN: a pair fires when `a_valid && b_valid`. `a_ready = b_ready = (RUN && a_valid && b_valid)`, so one stream is never consumed alone. Each fire decrements the remaining counter. After the last fire, go to DRAIN.
  - DRAIN: one cycle carrying the last `mac_en`. Then go to SETTLE.
  - SETTLE: `mac_c` is final. Capture `mac_c` into `res_data` at the end of the cycle and go to RESULT.
  - RESULT: `res_valid`=1 and `res_data` is held. On `res_ready`, go to IDLE.
- `mac_en`, `mac_a`, `mac_b` are registered. On the cycle after a fire: `mac_en`=1, `mac_a`/`mac_b` = the fired data. Otherwise `mac_en`=0 and the data holds its last value.
- `mac_en` and `mac_clr` are never high in the same cycle.
- `start` outside IDLE is ignored, including in the cycle `res_ready` returns to IDLE.
- Arithmetic is done entirely in `MAC`. The sum is exact whenever `LEN_WIDTH` ≤ `DATA_WIDTH`. The sequencer never modifies `mac_c`.
- Reset mid-operation: go to IDLE immediately. Any operand accepted before reset is lost. `MAC` is not cleared by reset; the next command's CLEAR handles it.
- Reset value of every output is 0 (`busy`, `a_ready`, `b_ready`, `mac_en`, `mac_clr`, `mac_a`, `mac_b`, `res_valid`, `res_data`, `stall_cnt`).

## Timing
- Worked timeline for len=1 with both streams valid (edge k is the rising edge that ends cycle k):
  - Cycle 0: `start` accepted; edge 0 leaves IDLE.
  - Cycle 1: `mac_clr`.
  - Cycle 2: fire.
  - Cycle 3: `mac_en` (DRAIN); `MAC` updates at edge 3.
  - Cycle 4: SETTLE capture.
  - Cycle 5: `res_valid`.
- Latency from accepting `start` to `res_valid` is N+4 cycles for N pairs with no stalls.
- len=0: latency is 3 cycles, `res_data`=0.
- Back-to-back fires: one pair per cycle, and `mac_en` is continuous.
- `busy` rises the cycle after `start` is accepted. It falls the cycle after the `res_valid && res_ready` handshake.

## Configuration
- `MAC_SEQ_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - It counts RUN cycles with no fire.
  - It clears when `start` is accepted and saturates at 16'hFFFF.
  - It holds its value after the run until the next start.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `mac_pkg` holds:
  - state enum `mac_seq_state_t` (IDLE, CLEAR, RUN, DRAIN, SETTLE, RESULT);
  - localparam `MAC_ACC_MULT` = 3, used for the accumulator width;
  - `STALL_CNT_WIDTH` = 16.
- No sub-module. `MAC` is instantiated next to `mac_seq` in the parent, not inside it.

## Test plan
- Reset then len=1, A=2, B=2 always valid -> `mac_clr` pulse, one `mac_en`, `res_valid` with `res_data`=4 at start+5 cycles; `busy` drops after `res_ready`.
- len=3, pairs (2,2), (3,4), (1,5), with `b_valid` low for 2 cycles before the second pair -> `a_ready` stays low during the gap, `res_data`=21, `stall_cnt`=2 (macro on).
- len=0 -> `mac_en` never high, `res_data`=0 after 3 cycles.
- Two commands back-to-back: first len=2 of (255,255), then len=1 of (1,1) -> results 130050 then 1, proving CLEAR between commands.
- `res_ready` held low for 5 cycles -> `res_valid` and `res_data` are held; `start` is ignored while held.
- `rst` asserted in RUN after 1 of 4 pairs -> all outputs 0 next cycle; a new len=1 (2,2) command returns 4.
